// File: rtl/controlador_divisor.sv
// ============================================================================
// Module  : controlador_divisor
// Brief   : Single-counter timebase producing fast/slow clock-enable ticks,
//           with run/pause/stop sequencing and a glitch-free limit update.
//           Optional square-wave outputs: CONTROLADOR_ONDA_QUADRADA_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_divisor #(
   parameter int               WIDTH         = 24,
   parameter int               FAST_BIT      = 5,
   parameter logic [WIDTH-1:0] DEFAULT_LIMIT = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic             i_stop,
   input  logic             i_cfg_valid,
   input  logic [WIDTH-1:0] i_cfg_limit,
   output logic             o_cfg_ready,
   output logic             o_tick_fast,
   output logic             o_tick_slow,
   output logic             o_running,
   output logic [WIDTH-1:0] o_count
`ifdef CONTROLADOR_ONDA_QUADRADA_EN
   ,
   output logic             o_onda_rapida,
   output logic             o_onda_lenta
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_limit;
   logic [WIDTH-1:0] r_pend_limit;
   logic             r_pend_valid;
   logic             r_tick_fast;
   logic             r_tick_slow;

   logic             w_xfer;
   logic             w_in_run;
   logic             w_wrap;
   logic             w_fast_hit;
   logic             w_pend_any;
   logic [WIDTH-1:0] w_pend_val;

   assign o_cfg_ready = ~r_pend_valid;
   assign w_xfer      = i_cfg_valid & ~r_pend_valid;
   assign w_in_run    = (r_state == S_RUN);
   assign w_wrap      = (r_count == r_limit);
   // Fast phase realigns at every wrap so both tick streams share a common origin.
   assign w_fast_hit  = (&r_count[FAST_BIT-1:0]) | w_wrap;
   assign w_pend_any  = r_pend_valid | w_xfer;
   assign w_pend_val  = w_xfer ? i_cfg_limit : r_pend_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_limit      <= DEFAULT_LIMIT;
         r_pend_limit <= '0;
         r_pend_valid <= 1'b0;
         r_tick_fast  <= 1'b0;
         r_tick_slow  <= 1'b0;
      end else begin
         r_tick_slow <= w_in_run & w_wrap;
         r_tick_fast <= w_in_run & w_fast_hit;

         // Idle (or entering idle) takes a new limit at once; otherwise it waits for a wrap.
         if (i_stop || (r_state == S_IDLE)) begin
            if (w_pend_any) begin
               r_limit <= w_pend_val;
            end
            r_pend_valid <= 1'b0;
         end else begin
            if (w_in_run && w_wrap && r_pend_valid) begin
               r_limit      <= r_pend_limit;
               r_pend_valid <= 1'b0;
            end else begin
               r_pend_valid <= w_pend_any;
            end
            if (w_xfer) begin
               r_pend_limit <= i_cfg_limit;
            end
         end

         if (i_stop) begin
            r_count <= '0;
         end else begin
            unique case (r_state)
               S_IDLE:   r_count <= '0;
               S_RUN:    r_count <= w_wrap ? '0 : r_count + {{(WIDTH-1){1'b0}}, 1'b1};
               S_PAUSED: r_count <= r_count;
               default:  r_count <= '0;
            endcase
         end

         if (i_stop) begin
            r_state <= S_IDLE;
         end else begin
            unique case (r_state)
               S_IDLE:   if (i_start) r_state <= S_RUN;
               S_RUN:    if (i_pause) r_state <= S_PAUSED;
               S_PAUSED: if (i_start) r_state <= S_RUN;
               default:  r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_tick_fast = r_tick_fast;
   assign o_tick_slow = r_tick_slow;
   assign o_running   = w_in_run;
   assign o_count     = r_count;

`ifdef CONTROLADOR_ONDA_QUADRADA_EN
   logic r_onda_rapida;
   logic r_onda_lenta;

   // Toggle on the same edge that registers the tick, so the waves only move while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_onda_rapida <= 1'b0;
         r_onda_lenta  <= 1'b0;
      end else if (i_stop) begin
         r_onda_rapida <= 1'b0;
         r_onda_lenta  <= 1'b0;
      end else if (w_in_run) begin
         if (w_fast_hit) r_onda_rapida <= ~r_onda_rapida;
         if (w_wrap)     r_onda_lenta  <= ~r_onda_lenta;
      end
   end

   assign o_onda_rapida = r_onda_rapida;
   assign o_onda_lenta  = r_onda_lenta;
`endif

endmodule

`default_nettype wire
